// File: rtl/uart_wb_master.sv
// UART-to-Wishbone debug master: decodes 'w', 'r' and 'g' byte commands into bus cycles and CPU restarts.
// Optional bus timeout enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_master #(
    parameter int         WB_TIMEOUT = 255,
    parameter logic [7:0] ECHO_ACK   = 8'h6B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_avail,
    output logic        rx_ack,
    output logic [7:0]  tx_data,
    output logic        tx_wr,
    input  logic        tx_busy,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    output logic        go,
    output logic [31:0] go_adr,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_WB   = 3'd3,
        ST_GO   = 3'd4,
        ST_TX   = 3'd5
    } state_t;

    localparam logic [7:0]  CMD_WRITE = 8'h77;
    localparam logic [7:0]  CMD_READ  = 8'h72;
    localparam logic [7:0]  CMD_GO    = 8'h67;
    localparam logic [7:0]  ERR_BYTE  = 8'h65;
    localparam logic [15:0] TO_LAST   = 16'(WB_TIMEOUT - 1);

`ifdef UART_WB_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    state_t      state_r;
    logic [7:0]  cmd_r;
    logic [1:0]  cnt_r;
    logic [1:0]  tx_cnt_r;
    logic [1:0]  tx_last_r;
    logic [31:0] tx_buf_r;
    logic        rx_gap_r;
    logic        tx_gap_r;
    logic [15:0] to_cnt_r;
    logic        rx_take_s;
    logic        tx_free_s;
    logic        to_hit_s;

    // The uart flags lag our strobes by a cycle, so both the cycle of a strobe and the one after it are blind.
    assign rx_take_s = rx_avail && !rx_ack && !rx_gap_r;
    assign tx_free_s = !tx_busy && !tx_wr && !tx_gap_r;
    assign to_hit_s  = TIMEOUT_EN && (to_cnt_r == TO_LAST);

    // Command FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cmd_r     <= 8'h00;
            cnt_r     <= 2'd0;
            tx_cnt_r  <= 2'd0;
            tx_last_r <= 2'd0;
            tx_buf_r  <= 32'h0000_0000;
            rx_gap_r  <= 1'b0;
            tx_gap_r  <= 1'b0;
            to_cnt_r  <= 16'd0;
            rx_ack    <= 1'b0;
            tx_data   <= 8'h00;
            tx_wr     <= 1'b0;
            wb_adr_o  <= 32'h0000_0000;
            wb_dat_o  <= 32'h0000_0000;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            go        <= 1'b0;
            go_adr    <= 32'h0000_0000;
            busy      <= 1'b0;
        end else begin
            rx_ack   <= 1'b0;
            tx_wr    <= 1'b0;
            go       <= 1'b0;
            rx_gap_r <= rx_ack;
            tx_gap_r <= tx_wr;
            case (state_r)
                ST_IDLE: begin
                    if (rx_take_s) begin
                        rx_ack <= 1'b1;
                        cnt_r  <= 2'd0;
                        if (rx_data == CMD_WRITE || rx_data == CMD_READ || rx_data == CMD_GO) begin
                            cmd_r   <= rx_data;
                            state_r <= ST_ADDR;
                            busy    <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_take_s) begin
                        rx_ack   <= 1'b1;
                        wb_adr_o <= {wb_adr_o[23:0], rx_data};
                        cnt_r    <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            case (cmd_r)
                                CMD_WRITE: state_r <= ST_DATA;
                                CMD_GO:    state_r <= ST_GO;
                                default:   state_r <= ST_WB;
                            endcase
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_take_s) begin
                        rx_ack   <= 1'b1;
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        cnt_r    <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            state_r <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_we_o  <= (cmd_r == CMD_WRITE);
                        to_cnt_r <= 16'd0;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_sel_o <= 4'h0;
                        wb_we_o  <= 1'b0;
                        to_cnt_r <= 16'd0;
                        tx_cnt_r <= 2'd0;
                        state_r  <= ST_TX;
                        if (cmd_r == CMD_WRITE) begin
                            tx_buf_r  <= {ECHO_ACK, 24'h00_0000};
                            tx_last_r <= 2'd0;
                        end else begin
                            tx_buf_r  <= wb_dat_i;
                            tx_last_r <= 2'd3;
                        end
                    end else if (to_hit_s) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        wb_we_o   <= 1'b0;
                        to_cnt_r  <= 16'd0;
                        tx_buf_r  <= {ERR_BYTE, 24'h00_0000};
                        tx_last_r <= 2'd0;
                        tx_cnt_r  <= 2'd0;
                        state_r   <= ST_TX;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                    end
                end
                ST_GO: begin
                    go        <= 1'b1;
                    go_adr    <= wb_adr_o;
                    tx_buf_r  <= {ECHO_ACK, 24'h00_0000};
                    tx_last_r <= 2'd0;
                    tx_cnt_r  <= 2'd0;
                    state_r   <= ST_TX;
                end
                ST_TX: begin
                    if (tx_free_s) begin
                        tx_wr    <= 1'b1;
                        tx_data  <= tx_buf_r[31:24];
                        tx_buf_r <= {tx_buf_r[23:0], 8'h00};
                        tx_cnt_r <= tx_cnt_r + 2'd1;
                        if (tx_cnt_r == tx_last_r) begin
                            state_r <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    busy     <= 1'b0;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    wb_sel_o <= 4'h0;
                    wb_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master: a table of command vectors plus hand-written back-pressure,
// reset-abort and (with UART_WB_TIMEOUT_EN) bus-timeout sequences.
module tb_uart_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_avail;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        go;
    logic [31:0] go_adr;
    logic        busy;

    uart_wb_master #(.WB_TIMEOUT(16), .ECHO_ACK(8'h6B)) dut (
        .clk(clk), .reset(rst),
        .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
        .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i),
        .go(go), .go_adr(go_adr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Wishbone slave: acks slave_lat cycles after cyc rises (0 = never acks)
    int          slave_lat = 1;
    logic [31:0] slave_rdata = 32'h0;
    int          wait_cnt = 0;
    always @(posedge clk) begin
        if (rst || !(wb_cyc_o && wb_stb_o) || wb_ack_i || slave_lat == 0) begin
            wb_ack_i <= 1'b0;
            wait_cnt <= 0;
        end else if (wait_cnt == slave_lat - 1) begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= slave_rdata;
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    // UART transmitter model: busy rises one cycle late after tx_wr and stays for three cycles
    logic force_busy = 1'b0;
    logic tx_pend = 1'b0;
    int   busy_cnt = 0;
    assign tx_busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        tx_pend <= tx_wr;
        if (tx_pend) busy_cnt <= 3;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Output monitors sampled on the falling edge
    int          cyc_no = 0, n_rxack = 0, last_rxack_at = 0, first_cyc_at = 0, cyc_hi = 0;
    int          n_unstable = 0, n_go = 0, n_txviol = 0, n_wbacks = 0;
    logic        prev_cyc = 1'b0;
    logic [31:0] mon_adr = 32'h0, mon_dat = 32'h0, last_go_adr = 32'h0;
    logic        mon_we = 1'b0;
    logic [3:0]  mon_sel = 4'h0;
    logic [7:0]  txq[$];
    always @(negedge clk) begin
        cyc_no <= cyc_no + 1;
        if (rx_ack) begin
            n_rxack <= n_rxack + 1;
            last_rxack_at <= cyc_no;
        end
        if (wb_cyc_o) begin
            cyc_hi <= cyc_hi + 1;
            if (!prev_cyc) begin
                first_cyc_at <= cyc_no;
                mon_adr <= wb_adr_o;
                mon_dat <= wb_dat_o;
                mon_we  <= wb_we_o;
                mon_sel <= wb_sel_o;
            end else if (wb_adr_o != mon_adr || wb_dat_o != mon_dat || wb_we_o != mon_we || wb_sel_o != mon_sel) begin
                n_unstable <= n_unstable + 1;
            end
            if (wb_ack_i) n_wbacks <= n_wbacks + 1;
        end
        if (wb_cyc_o != wb_stb_o) n_unstable <= n_unstable + 1;
        prev_cyc <= wb_cyc_o;
        if (tx_wr) begin
            txq.push_back(tx_data);
            if (tx_busy) n_txviol <= n_txviol + 1;
        end
        if (go) begin
            n_go <= n_go + 1;
            last_go_adr <= go_adr;
        end
    end

    typedef struct {
        logic [71:0] bytes;
        int          nb;
        int          ack_lat;
        logic [31:0] rdata;
        int          exp_ack;
        int          exp_cyc;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_we;
        int          exp_ntx;
        logic [31:0] exp_tx;
        int          exp_go;
        logic [31:0] exp_go_adr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [71:0] bytes, input int nb, input int ack_lat, input logic [31:0] rdata,
                           input int exp_ack, input int exp_cyc, input logic [31:0] exp_adr,
                           input logic [31:0] exp_dat, input logic exp_we, input int exp_ntx,
                           input logic [31:0] exp_tx, input int exp_go, input logic [31:0] exp_go_adr);
        vec_t v;
        v.bytes = bytes; v.nb = nb; v.ack_lat = ack_lat; v.rdata = rdata;
        v.exp_ack = exp_ack; v.exp_cyc = exp_cyc; v.exp_adr = exp_adr; v.exp_dat = exp_dat;
        v.exp_we = exp_we; v.exp_ntx = exp_ntx; v.exp_tx = exp_tx; v.exp_go = exp_go;
        v.exp_go_adr = exp_go_adr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        rx_data  = b;
        rx_avail = 1'b1;
        k = 0;
        @(negedge clk);
        while (!rx_ack && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("rx_ack_seen", {127'h0, rx_ack}, 128'h1);
        @(posedge clk);
        #1;
        rx_avail = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 1000 && busy; k++) @(negedge clk);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int rx0, cyc0, go0, tx0, viol0, uns0, ack0;
        rx0 = n_rxack; cyc0 = cyc_hi; go0 = n_go; tx0 = txq.size();
        viol0 = n_txviol; uns0 = n_unstable; ack0 = n_wbacks;
        slave_lat = v.ack_lat;
        slave_rdata = v.rdata;
        for (int i = 0; i < v.nb; i++) send_byte(v.bytes[71 - 8*i -: 8]);
        wait_idle();
        chk({tag, ".rx_ack_count"}, n_rxack - rx0, v.nb);
        chk({tag, ".wb_acks"}, n_wbacks - ack0, v.exp_ack);
        chk({tag, ".cyc_cycles"}, cyc_hi - cyc0, v.exp_cyc);
        if (v.exp_cyc != 0) begin
            chk({tag, ".wb_adr"}, mon_adr, v.exp_adr);
            chk({tag, ".wb_we"}, mon_we, v.exp_we);
            chk({tag, ".wb_sel"}, mon_sel, 4'hF);
            chk({tag, ".wb_start_latency"}, first_cyc_at - last_rxack_at, 1);
            if (v.exp_we) chk({tag, ".wb_dat"}, mon_dat, v.exp_dat);
        end
        chk({tag, ".tx_count"}, txq.size() - tx0, v.exp_ntx);
        for (int i = 0; i < v.exp_ntx; i++) begin
            if (tx0 + i < txq.size()) chk({tag, ".tx_byte"}, txq[tx0 + i], v.exp_tx[31 - 8*i -: 8]);
        end
        chk({tag, ".go_pulses"}, n_go - go0, v.exp_go);
        if (v.exp_go != 0) chk({tag, ".go_adr"}, last_go_adr, v.exp_go_adr);
        chk({tag, ".tx_while_busy"}, n_txviol - viol0, 0);
        chk({tag, ".wb_unstable"}, n_unstable - uns0, 0);
        chk({tag, ".busy_end"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int tx0, rx0, viol0;
        rst = 1'b1; rx_data = 8'h00; rx_avail = 1'b0;

        add_vec({8'h77, 8'h00, 8'h00, 8'h10, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 9, 1, 32'h0,
                1, 2, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1, 32'h6B00_0000, 0, 32'h0);
        add_vec({8'h72, 8'h00, 8'h00, 8'h10, 8'h00, 32'h0}, 5, 5, 32'h1234_5678,
                1, 6, 32'h0000_1000, 32'h0, 1'b0, 4, 32'h1234_5678, 0, 32'h0);
        add_vec({8'h67, 8'h40, 8'h00, 8'h00, 8'h00, 32'h0}, 5, 1, 32'h0,
                0, 0, 32'h0, 32'h0, 1'b0, 1, 32'h6B00_0000, 1, 32'h4000_0000);
        add_vec({8'h55, 64'h0}, 1, 1, 32'h0,
                0, 0, 32'h0, 32'h0, 1'b0, 0, 32'h0, 0, 32'h0);
        add_vec({8'h77, 8'h12, 8'h34, 8'h56, 8'h7B, 8'h01, 8'h02, 8'h03, 8'h04}, 9, 3, 32'h0,
                1, 4, 32'h1234_567B, 32'h0102_0304, 1'b1, 1, 32'h6B00_0000, 0, 32'h0);
        add_vec({8'h72, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'h0}, 5, 2, 32'hA5C3_0F81,
                1, 3, 32'hFFFF_FFFF, 32'h0, 1'b0, 4, 32'hA5C3_0F81, 0, 32'h0);
        add_vec({8'h67, 8'h00, 8'h00, 8'h01, 8'h23, 32'h0}, 5, 1, 32'h0,
                0, 0, 32'h0, 32'h0, 1'b0, 1, 32'h6B00_0000, 1, 32'h0000_0123);
`ifdef UART_WB_TIMEOUT_EN
        add_vec({8'h72, 8'h00, 8'h00, 8'h20, 8'h04, 32'h0}, 5, 0, 32'h0,
                0, 16, 32'h0000_2004, 32'h0, 1'b0, 1, 32'h6500_0000, 0, 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {13'h0, rx_ack, tx_wr, tx_data, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o, go, go_adr, busy},
            128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Garbage byte then a read while the transmitter is held busy
        force_busy = 1'b1;
        tx0 = txq.size(); rx0 = n_rxack; viol0 = n_txviol;
        slave_lat = 3; slave_rdata = 32'hCAFE_F00D;
        send_byte(8'h55);
        send_byte(8'h72); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        repeat (100) @(posedge clk);
        #1;
        chk("bp.tx_held", txq.size() - tx0, 0);
        chk("bp.busy_held", busy, 1);
        force_busy = 1'b0;
        wait_idle();
        chk("bp.tx_count", txq.size() - tx0, 4);
        if (txq.size() >= tx0 + 4) begin
            chk("bp.tx_bytes", {txq[tx0], txq[tx0+1], txq[tx0+2], txq[tx0+3]}, 32'hCAFE_F00D);
        end
        chk("bp.rx_ack_count", n_rxack - rx0, 6);
        chk("bp.tx_while_busy", n_txviol - viol0, 0);

        // Reset while a write cycle is waiting for its ack
        slave_lat = 50;
        send_byte(8'h77); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        for (int k = 0; k < 20 && !wb_cyc_o; k++) @(negedge clk);
        @(negedge clk);
        chk("abort.cyc_before", {wb_cyc_o, wb_we_o}, 2'b11);
        tx0 = txq.size();
        rst = 1'b1;
        #1;
        chk("abort.outputs", {wb_cyc_o, wb_stb_o, wb_we_o, busy}, 4'b0000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.no_tx", txq.size() - tx0, 0);
        run_vec(vecs[0], "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- Debug/boot controller that turns command bytes from the system UART into Wishbone master cycles (reads, writes, jump requests).
- Sits between the uart core's byte interface and a master port of the system Wishbone interconnect.
- Lets a host load and inspect memory (DDR, BRAM, peripherals) and start the LM32 at a given address without firmware support.

Parameters:
- WB_TIMEOUT, 255, cycles to wait for wb_ack_i before aborting; only used when UART_WB_TIMEOUT_EN is defined.
- ECHO_ACK, 8'h6B, byte ('k') sent after a completed write or go command.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from uart
- rx_avail  in  1  rx_data valid; held until acknowledged
- rx_ack  out  1  one-cycle pulse consuming rx_data
- tx_data  out  8  byte to transmit
- tx_wr  out  1  one-cycle transmit strobe
- tx_busy  in  1  uart transmitter busy
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_sel_o  out  4  byte select, always 4'hF during a cycle
- wb_we_o  out  1  write enable
- wb_stb_o  out  1  strobe
- wb_cyc_o  out  1  cycle
- wb_ack_i  in  1  acknowledge
- go  out  1  one-cycle pulse requesting CPU restart
- go_adr  out  32  restart address; valid while go=1, held afterwards
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM in IDLE, byte counters 0.
- Byte intake:
  - In any state that expects a byte, when rx_avail=1, latch rx_data and pulse rx_ack for exactly one cycle.
  - Do not sample rx_avail in the cycle immediately after an rx_ack pulse.
- Commands (first byte):
  - 'w' (8'h77): 4 address bytes, then 4 data bytes, both MSB first. Then one write cycle; reply ECHO_ACK.
  - 'r' (8'h72): 4 address bytes. Then one read cycle; reply 4 bytes of wb_dat_i, MSB first.
  - 'g' (8'h67): 4 address bytes. Then go_adr <= address and go pulses one cycle; reply ECHO_ACK.
  - Any other first byte is consumed and discarded; FSM stays IDLE, nothing transmitted.
- FSM states and transitions:
  - IDLE -> CMD decode.
  - ADDR: count 0..3, shift left 8 per byte.
  - DATA: count 0..3, 'w' only.
  - WB: assert cyc/stb/sel (and we for 'w') from the cycle after the last byte.
    - Hold until wb_ack_i=1; deassert cyc/stb/we in the following cycle.
    - Read data is latched on the ack cycle.
  - GO: one cycle.
  - TX: for each reply byte, wait tx_busy=0, then drive tx_data and pulse tx_wr for one cycle. Ignore tx_busy for one cycle after each tx_wr, since the uart raises busy one cycle late.
  - TX -> IDLE after the last byte.
- Latency:
  - Write: first Wishbone cycle starts 1 clk after the rx_ack of the 8th payload byte.
  - wb_adr_o/wb_dat_o are stable for the whole cycle and keep their value after it.
- Address register is 32 bits; no wrap or alignment enforcement. The low 2 bits are passed through unchanged.
- wb_ack_i outside WB state is ignored.
- rx_avail during WB/TX/GO is not consumed (no rx_ack) until the FSM returns to a byte-expecting state.
- Reset mid-operation: cyc/stb drop immediately (async), partial command discarded, any pending tx_wr suppressed.

Optional Feature:
- Macro UART_WB_TIMEOUT_EN.
- Defined: a counter starts at wb_cyc_o rise.
  - If WB_TIMEOUT cycles elapse without wb_ack_i, drop cyc/stb next cycle and reply the single byte 8'h65 ('e') for any command type, instead of normal data.
  - Counter clears on ack.
- Not defined: WB state waits indefinitely for wb_ack_i and 8'h65 is never sent.

Test Plan:
- Write: send 77,00,00,10,00,DE,AD,BE,EF -> one cycle with adr=32'h00001000, dat=32'hDEADBEEF, we=1, sel=F; tx byte 6B.
- Read-back: slave returns 32'h12345678 on ack delayed 5 clk for adr 32'h00001000 -> cyc/stb held 6 clk; tx bytes 12,34,56,78 in order, each tx_wr only while tx_busy=0.
- Go: send 67,40,00,00,00 -> go pulses exactly 1 clk with go_adr=32'h40000000; tx 6B; no Wishbone cycle.
- Garbage and back-pressure: send 55 then a valid 'r' command with tx_busy forced high 100 clk -> 55 consumed silently; the four read reply bytes are delayed until tx_busy falls, no byte lost or duplicated.
- Reset abort: assert reset while wb_cyc_o=1 -> cyc/stb/we go 0 the same cycle, busy=0. A subsequent full write command works normally.
- Timeout (UART_WB_TIMEOUT_EN, WB_TIMEOUT=16): 'r' to a non-acking slave -> cyc drops after 16 clk, tx byte 65, FSM back to IDLE.
